down_counter_timer: RTL and testbench

//  Loadable, pausable down-counter/timer, the down-direction companion of up_counter.

---
 rtl/down_counter_timer_pkg.sv | 15 +
 rtl/down_counter_timer.sv | 103 ++++++++++
 tb/tb_down_counter_timer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter/timer: default width and the
// FSM state encoding, kept identical to the up_counter encoding so both
// counters read the same in waveforms and debug tooling.
package down_counter_timer_pkg;

  // Default counter width, shared with up_counter
  localparam int COUNTER_WIDTH = 8;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable, pausable down-counter/timer. Counts a programmed value down to
// zero one step per clock, pulses done on expiry and can auto-reload to
// produce a periodic tick. All outputs are registered.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CountZero = '0;
  localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // start only counts as a request when neither load nor stop outranks it
  logic startReq;
  assign startReq = start && !stop;

  // Next-state logic: load beats stop, stop beats start, and the count
  // never decrements past zero because expiry is handled at count==1.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      reload_d = load_value;
      count_d  = load_value;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (startReq && (count_q != CountZero)) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (startReq && (reload_q != CountZero)) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (count_q > CountOne) begin
            count_d = count_q - CountOne;
          end else if (auto_reload) begin
            count_d = reload_q;
            done_d  = 1'b1;
          end else begin
            count_d = CountZero;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= CountZero;
      reload_q <= CountZero;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (WIDTH=8): a table of
// per-cycle vectors plus hand-written sequences for reset, hold and the
// full-range count.
module tb_down_counter_timer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         ld;
    logic [W-1:0] val;
    logic         st;
    logic         sp;
    logic         ar;
    logic [W-1:0] expCount;
    logic         expBusy;
    logic         expDone;
  } vector_t;

  vector_t vecs[$];

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge
  task automatic applyStimulus(input logic ld, input logic [W-1:0] val,
                               input logic st, input logic sp, input logic ar);
    @(negedge clk);
    load        = ld;
    load_value  = val;
    start       = st;
    stop        = sp;
    auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  // One comparison of the full output tuple
  task automatic checkOutput(input string name, input logic [W-1:0] expCount,
                             input logic expBusy, input logic expDone);
    total++;
    if (count !== expCount || busy !== expBusy || done !== expDone) begin
      bad++;
      $display("[TB] FAIL %s: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
               name, count, busy, done, expCount, expBusy, expDone);
    end
  endtask

  // Append one table row
  task automatic addVec(input logic ld, input logic [W-1:0] val, input logic st,
                        input logic sp, input logic ar, input logic [W-1:0] ec,
                        input logic eb, input logic ed);
    vector_t v;
    v.ld = ld; v.val = val; v.st = st; v.sp = sp; v.ar = ar;
    v.expCount = ec; v.expBusy = eb; v.expDone = ed;
    vecs.push_back(v);
  endtask

  // Main test sequence
  initial begin
    int doneEdge;
    int onesSeen;

    reset       = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    start       = 1'b0;
    stop        = 1'b0;
    auto_reload = 1'b0;

    // Reset state
    #3;
    checkOutput("reset_initial", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-run: load 9, start, 3 cycles, then assert reset between edges
    applyStimulus(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_run_entry", 8'd9, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_run_before", 8'd6, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("reset_async", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_quiet", 8'd0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_start_zero", 8'd0, 1'b0, 1'b0);

    // Table: ld val st sp ar | count busy done
    // One-shot from 5
    addVec(1, 5, 0, 0, 0,   5, 0, 0);
    addVec(0, 0, 1, 0, 0,   5, 1, 0);
    addVec(0, 0, 0, 0, 0,   4, 1, 0);
    addVec(0, 0, 0, 0, 0,   3, 1, 0);
    addVec(0, 0, 0, 0, 0,   2, 1, 0);
    addVec(0, 0, 0, 0, 0,   1, 1, 0);
    addVec(0, 0, 0, 0, 0,   0, 0, 1);
    addVec(0, 0, 0, 0, 0,   0, 0, 0);
    addVec(0, 0, 0, 0, 0,   0, 0, 0);
    // Periodic from 3, then auto_reload cleared mid-period
    addVec(1, 3, 0, 0, 1,   3, 0, 0);
    addVec(0, 0, 1, 0, 1,   3, 1, 0);
    addVec(0, 0, 0, 0, 1,   2, 1, 0);
    addVec(0, 0, 0, 0, 1,   1, 1, 0);
    addVec(0, 0, 0, 0, 1,   3, 1, 1);
    addVec(0, 0, 0, 0, 1,   2, 1, 0);
    addVec(0, 0, 0, 0, 1,   1, 1, 0);
    addVec(0, 0, 0, 0, 1,   3, 1, 1);
    addVec(0, 0, 0, 0, 0,   2, 1, 0);
    addVec(0, 0, 0, 0, 0,   1, 1, 0);
    addVec(0, 0, 0, 0, 0,   0, 0, 1);
    addVec(0, 0, 0, 0, 0,   0, 0, 0);
    // Start in DONE reruns from reload value 3
    addVec(0, 0, 1, 0, 0,   3, 1, 0);
    addVec(0, 0, 0, 0, 0,   2, 1, 0);
    // Load aborts the run; then pause at 4
    addVec(1, 6, 0, 0, 0,   6, 0, 0);
    addVec(0, 0, 1, 0, 0,   6, 1, 0);
    addVec(0, 0, 0, 0, 0,   5, 1, 0);
    addVec(0, 0, 0, 0, 0,   4, 1, 0);
    addVec(0, 0, 0, 1, 0,   4, 0, 0);
    addVec(0, 0, 0, 1, 0,   4, 0, 0);
    addVec(0, 0, 0, 0, 0,   4, 0, 0);
    addVec(0, 0, 1, 0, 0,   4, 1, 0);
    addVec(0, 0, 0, 0, 0,   3, 1, 0);
    addVec(0, 0, 1, 1, 0,   3, 0, 0);
    addVec(0, 0, 1, 0, 0,   3, 1, 0);
    addVec(0, 0, 1, 0, 0,   2, 1, 0);
    // Abort at 7 with load of 20
    addVec(1, 9, 0, 0, 0,   9, 0, 0);
    addVec(0, 0, 1, 0, 0,   9, 1, 0);
    addVec(0, 0, 0, 0, 0,   8, 1, 0);
    addVec(0, 0, 0, 0, 0,   7, 1, 0);
    addVec(1, 20, 0, 0, 0, 20, 0, 0);
    addVec(0, 0, 0, 0, 0,  20, 0, 0);
    // Load 0 then start is ignored
    addVec(1, 0, 0, 0, 0,   0, 0, 0);
    addVec(0, 0, 1, 0, 0,   0, 0, 0);
    addVec(0, 0, 1, 0, 0,   0, 0, 0);
    // Stop ignored in IDLE and DONE; count of 2 expires on 3rd edge
    addVec(1, 2, 0, 0, 0,   2, 0, 0);
    addVec(0, 0, 0, 1, 0,   2, 0, 0);
    addVec(0, 0, 1, 0, 0,   2, 1, 0);
    addVec(0, 0, 0, 0, 0,   1, 1, 0);
    addVec(0, 0, 0, 0, 0,   0, 0, 1);
    addVec(0, 0, 0, 1, 0,   0, 0, 0);
    addVec(0, 0, 1, 0, 0,   2, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].sp, vecs[i].ar);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expBusy, vecs[i].expDone);
    end

    // One-shot of 1, then count must hold 0 for 10 cycles
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_entry", 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_expire", 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_zero", 8'd0, 1'b0, 1'b0);
    end

    // Full range: load 255, done must be on the 256th edge counting the start edge as 1
    applyStimulus(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    checkOutput("max_load", 8'd255, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("max_entry", 8'd255, 1'b1, 1'b0);
    doneEdge = 0;
    onesSeen = 0;
    for (int e = 2; e <= 400 && doneEdge == 0; e++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      if (done === 1'b1) doneEdge = e;
    end
    total++;
    if (doneEdge != 256) begin
      bad++;
      $display("[TB] FAIL max_latency: done edge=%0d, want 256", doneEdge);
    end
    checkOutput("max_expire", 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("max_done_once", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("max_rerun", 8'd255, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("max_rerun_dec", 8'd254, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
